// File: rtl/hdmi_island_scheduler.sv
// HDMI channel-period scheduler: for each pixel it selects control, video
// preamble/guard, data-island preamble/guard or packet payload. Every output
// is registered, so the value seen in cycle n+1 reflects the inputs sampled
// in cycle n.
module hdmi_island_scheduler #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned ISLAND_START = 652,
    parameter int unsigned MAX_PKTS     = 2
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       island_en,
    input  logic [9:0] counterX,
    input  logic [9:0] counterY,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       vde,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    output logic [4:0] pkt_word_idx,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       vde_o,
    output logic       ade,
    output logic [3:0] ctl,
    output logic       vid_gb,
    output logic       dat_gb,
    output logic       err_abort
);

    // Islands are only started when the geometry leaves room for them.
    localparam bit CFG_OK = (ISLAND_START >= H_ACTIVE + 12) &&
                            (MAX_PKTS >= 1) && (MAX_PKTS <= 2);

    localparam logic [9:0] X_ISLAND   = 10'(ISLAND_START);
    localparam logic [9:0] X_VPRE_LO  = 10'(H_TOTAL - 10);
    localparam logic [9:0] X_VPRE_HI  = 10'(H_TOTAL - 3);
    localparam logic [9:0] X_VGB_LO   = 10'(H_TOTAL - 2);
    localparam logic [9:0] X_VGB_HI   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] Y_PRE_ACT  = 10'(V_ACTIVE - 1);
    localparam logic [1:0] MAX_P      = 2'(MAX_PKTS);

    localparam logic [3:0] CTL_VIDEO  = 4'b0001;
    localparam logic [3:0] CTL_ISLAND = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LGB,
        S_DATA,
        S_TGB
    } state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [4:0] idx_q;
    logic [1:0] pkt_cnt_q;
    logic       more_q;
    logic       armed_q;

    logic       pre_line;
    logic [3:0] vid_ctl;
    logic       vid_gb_w;
    logic       start;

    // Video preamble/guard window, independent of the island FSM.
    always_comb begin
        vid_ctl  = '0;
        vid_gb_w = 1'b0;
        pre_line = (counterY == Y_LAST) || (counterY < Y_PRE_ACT);
        if (pre_line) begin
            if (counterX >= X_VPRE_LO && counterX <= X_VPRE_HI) vid_ctl = CTL_VIDEO;
            if (counterX >= X_VGB_LO && counterX <= X_VGB_HI)   vid_gb_w = 1'b1;
        end
        start = CFG_OK && armed_q && (counterX == X_ISLAND) && !vde &&
                island_en && pkt_valid;
    end

    // Island FSM with registered outputs; the state holds what was emitted last.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pkt_cnt_q    <= '0;
            more_q       <= 1'b0;
            armed_q      <= 1'b0;
            pkt_ready    <= 1'b0;
            pkt_word_idx <= '0;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
            vde_o        <= 1'b0;
            ade          <= 1'b0;
            ctl          <= '0;
            vid_gb       <= 1'b0;
            dat_gb       <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            hsync_o      <= hSync;
            vsync_o      <= vSync;
            vde_o        <= vde;
            pkt_ready    <= 1'b0;
            pkt_word_idx <= '0;
            ade          <= 1'b0;
            ctl          <= vid_ctl;
            vid_gb       <= vid_gb_w;
            dat_gb       <= 1'b0;
            err_abort    <= 1'b0;

            if (counterX == '0) armed_q <= 1'b1;

            if (state_q != S_IDLE && vde) begin
                // Active video has priority: drop the island without a pop.
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                idx_q     <= '0;
                pkt_cnt_q <= '0;
                more_q    <= 1'b0;
                err_abort <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_PRE;
                            cnt_q   <= '0;
                            armed_q <= 1'b0;
                            ctl     <= CTL_ISLAND;
                        end
                    end
                    S_PRE: begin
                        if (cnt_q == 3'd7) begin
                            state_q <= S_LGB;
                            cnt_q   <= '0;
                            dat_gb  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                            ctl   <= CTL_ISLAND;
                        end
                    end
                    S_LGB: begin
                        if (cnt_q == 3'd1) begin
                            state_q   <= S_DATA;
                            cnt_q     <= '0;
                            idx_q     <= '0;
                            pkt_cnt_q <= 2'd1;
                            more_q    <= 1'b0;
                            ade       <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            dat_gb <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (idx_q == 5'd31) begin
                            if (more_q) begin
                                idx_q     <= '0;
                                pkt_cnt_q <= pkt_cnt_q + 2'd1;
                                more_q    <= 1'b0;
                                ade       <= 1'b1;
                            end else begin
                                state_q <= S_TGB;
                                cnt_q   <= '0;
                                dat_gb  <= 1'b1;
                            end
                        end else begin
                            idx_q        <= idx_q + 5'd1;
                            pkt_word_idx <= idx_q + 5'd1;
                            ade          <= 1'b1;
                            // Word 31 goes out now: pop and decide on a follow-up packet.
                            if (idx_q == 5'd30) begin
                                pkt_ready <= pkt_valid;
                                more_q    <= pkt_valid && (pkt_cnt_q < MAX_P);
                            end
                        end
                    end
                    S_TGB: begin
                        if (cnt_q == 3'd1) begin
                            state_q   <= S_IDLE;
                            cnt_q     <= '0;
                            pkt_cnt_q <= '0;
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            dat_gb <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: drives whole lines of a 640x480
// timing and compares every registered output per pixel against hand-derived
// windows. A second instance is built with a one-packet island limit.
module tb_hdmi_island_scheduler;

    logic       pixel_clk = 1'b0;
    logic       reset;
    logic       island_en;
    logic [9:0] counterX;
    logic [9:0] counterY;
    logic       hSync;
    logic       vSync;
    logic       vde;
    logic       pkt_valid;

    logic       pkt_ready0, pkt_ready1;
    logic [4:0] idx0, idx1;
    logic       hs0, hs1, vs0, vs1, de0, de1, ade0, ade1;
    logic [3:0] ctl0, ctl1;
    logic       vgb0, vgb1, dgb0, dgb1, err0, err1;

    logic [16:0] act0, act1;
    int          errors = 0;
    int          checks = 0;

    always #5 pixel_clk = ~pixel_clk;

    hdmi_island_scheduler #(.MAX_PKTS(2)) dut (
        .pixel_clk(pixel_clk), .reset(reset), .island_en(island_en),
        .counterX(counterX), .counterY(counterY), .hSync(hSync), .vSync(vSync),
        .vde(vde), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready0),
        .pkt_word_idx(idx0), .hsync_o(hs0), .vsync_o(vs0), .vde_o(de0),
        .ade(ade0), .ctl(ctl0), .vid_gb(vgb0), .dat_gb(dgb0), .err_abort(err0)
    );

    hdmi_island_scheduler #(.MAX_PKTS(1)) dut1 (
        .pixel_clk(pixel_clk), .reset(reset), .island_en(island_en),
        .counterX(counterX), .counterY(counterY), .hSync(hSync), .vSync(vSync),
        .vde(vde), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready1),
        .pkt_word_idx(idx1), .hsync_o(hs1), .vsync_o(vs1), .vde_o(de1),
        .ade(ade1), .ctl(ctl1), .vid_gb(vgb1), .dat_gb(dgb1), .err_abort(err1)
    );

    assign act0 = {pkt_ready0, idx0, hs0, vs0, de0, ade0, ctl0, vgb0, dgb0, err0};
    assign act1 = {pkt_ready1, idx1, hs1, vs1, de1, ade1, ctl1, vgb1, dgb1, err1};

    function automatic logic f_vde(input int x, input int y);
        return (x < 640) && (y < 480);
    endfunction

    function automatic logic f_hs(input int x);
        return (x >= 656) && (x < 752);
    endfunction

    function automatic logic f_vs(input int y);
        return (y >= 490) && (y < 492);
    endfunction

    // Expected output vector for pixel x of line y; npk = packets in the island (0 = none).
    function automatic logic [16:0] exp_vec(input int x, input int y, input logic de, input int npk);
        logic       rdy = 1'b0;
        logic [4:0] idx = '0;
        logic       a   = 1'b0;
        logic [3:0] c   = '0;
        logic       vg  = 1'b0;
        logic       dg  = 1'b0;
        int         last;
        if (y == 524 || y < 479) begin
            if (x >= 790 && x <= 797) c = 4'b0001;
            if (x >= 798 && x <= 799) vg = 1'b1;
        end
        if (npk > 0) begin
            last = 662 + 32 * npk - 1;
            if (x >= 652 && x <= 659) c = 4'b0101;
            if (x == 660 || x == 661 || x == last + 1 || x == last + 2) dg = 1'b1;
            if (x >= 662 && x <= last) begin
                a   = 1'b1;
                idx = 5'((x - 662) % 32);
                if ((x - 662) % 32 == 31) rdy = 1'b1;
            end
        end
        return {rdy, idx, f_hs(x), f_vs(y), de, a, c, vg, dg, 1'b0};
    endfunction

    task automatic drive(input int x, input int y, input logic de_force);
        counterX = 10'(x);
        counterY = 10'(y);
        vde      = f_vde(x, y) | de_force;
        hSync    = f_hs(x);
        vSync    = f_vs(y);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        island_en = 1'b0;
        pkt_valid = 1'b0;
        drive(0, 0, 1'b0);
        checks++;
        if (act0 !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", act0, 17'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_two_packets(input int y);
        island_en = 1'b1;
        pkt_valid = 1'b1;
        for (int x = 0; x < 800; x++) begin
            logic [16:0] e;
            drive(x, y, 1'b0);
            e = exp_vec(x, y, f_vde(x, y), 2);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL two_packets x=%0d y=%0d got=%b exp=%b", x, y, act0, e);
            end
        end
    endtask

    task automatic test_single_packet;
        island_en = 1'b1;
        pkt_valid = 1'b1;
        for (int x = 0; x < 800; x++) begin
            logic [16:0] e;
            drive(x, 103, 1'b0);
            e = exp_vec(x, 103, f_vde(x, 103), 1);
            checks++;
            if (act1 !== e) begin
                errors++;
                $display("FAIL single_packet x=%0d got=%b exp=%b", x, act1, e);
            end
        end
    endtask

    task automatic test_late_valid;
        island_en = 1'b1;
        for (int x = 0; x < 800; x++) begin
            logic [16:0] e;
            pkt_valid = (x >= 700);
            drive(x, 101, 1'b0);
            e = exp_vec(x, 101, f_vde(x, 101), 0);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL late_valid x=%0d got=%b exp=%b", x, act0, e);
            end
        end
    endtask

    task automatic test_video_preamble;
        island_en = 1'b0;
        pkt_valid = 1'b1;
        for (int x = 0; x < 800; x++) begin
            logic [16:0] e;
            drive(x, 524, 1'b0);
            e = exp_vec(x, 524, 1'b0, 0);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL video_preamble x=%0d got=%b exp=%b", x, act0, e);
            end
        end
        for (int x = 0; x < 4; x++) begin
            logic [16:0] e;
            drive(x, 0, 1'b0);
            e = exp_vec(x, 0, 1'b1, 0);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL first_active x=%0d got=%b exp=%b", x, act0, e);
            end
        end
        for (int x = 4; x < 800; x++) drive(x, 0, 1'b0);
    endtask

    task automatic test_abort;
        island_en = 1'b1;
        pkt_valid = 1'b1;
        for (int x = 0; x < 800; x++) begin
            logic [16:0] e;
            drive(x, 200, x == 680);
            if (x < 680) e = exp_vec(x, 200, f_vde(x, 200), 2);
            else if (x == 680) begin
                e    = exp_vec(x, 200, 1'b1, 0);
                e[0] = 1'b1;
            end else e = exp_vec(x, 200, 1'b0, 0);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL abort x=%0d got=%b exp=%b", x, act0, e);
            end
        end
    endtask

    task automatic test_reset_mid_data;
        island_en = 1'b1;
        pkt_valid = 1'b1;
        for (int x = 0; x <= 674; x++) begin
            logic [16:0] e;
            drive(x, 300, 1'b0);
            e = exp_vec(x, 300, f_vde(x, 300), 2);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL pre_reset x=%0d got=%b exp=%b", x, act0, e);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (act0 !== 17'd0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", act0, 17'd0);
        end
        drive(675, 300, 1'b0);
        checks++;
        if (act0 !== 17'd0) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", act0, 17'd0);
        end
        reset = 1'b0;
        for (int x = 676; x < 800; x++) begin
            logic [16:0] e;
            drive(x, 300, 1'b0);
            e = exp_vec(x, 300, f_vde(x, 300), 0);
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL post_reset x=%0d got=%b exp=%b", x, act0, e);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        island_en = 1'b0;
        pkt_valid = 1'b0;
        counterX  = '0;
        counterY  = '0;
        hSync     = 1'b0;
        vSync     = 1'b0;
        vde       = 1'b0;
        test_reset();
        test_two_packets(100);
        test_late_valid();
        test_two_packets(102);
        test_single_packet();
        test_video_preamble();
        test_abort();
        test_reset_mid_data();
        test_two_packets(301);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
